// File: rtl/csm_port_arbiter.sv
// Two-port arbiter for a shared register bank: round-robin on contention, one access
// per three cycles, per-register hold/release locks with per-port idle timeout.
module csm_port_arbiter #(
  parameter int NUM_REGS     = 4,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 8,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_hold,
  input  logic              a_release,
  output logic              a_ack,
  output logic [1:0]        a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_rw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_hold,
  input  logic              b_release,
  output logic              b_ack,
  output logic [1:0]        b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: x_req rises with x_rw/x_addr/x_wdata/x_hold/x_release and keeps them stable
  // until x_ack; x_ack is a one-cycle pulse carrying x_err/x_rdata; a req still high in the
  // IDLE cycle after x_ack is taken as a fresh request.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GRANT = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_FREE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_t;

  localparam int         TBL         = 1 << ADDR_W;
  localparam bit         PARTIAL     = NUM_REGS < TBL;
  localparam int         CNT_W       = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_LOCKED  = 2'b01;
  localparam logic [1:0] ERR_BADREL  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  state_t             state;
  owner_t             owner [TBL];
  logic               sel_b;
  logic               favour_b;
  logic               cur_rw;
  logic               cur_hold;
  logic               cur_rel;
  logic [ADDR_W-1:0]  cur_addr;
  logic [1:0]         cur_err;
  logic               rd_a;
  logic               rd_b;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;

  logic               win_b;
  logic               w_rw;
  logic               w_hold;
  logic               w_rel;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  owner_t             w_self;
  owner_t             w_other;
  logic [1:0]         w_err;
  logic               owns_a;
  logic               owns_b;
  logic               grant_a_now;
  logic               grant_b_now;
  logic               to_a;
  logic               to_b;

  assign dbg_state = state;
  // Read data arrives from the bank during RESP, so it is steered straight to the acked port.
  assign a_rdata = rd_a ? mem_rdata : '0;
  assign b_rdata = rd_b ? mem_rdata : '0;

  always_comb begin
    win_b   = b_req && (!a_req || favour_b);
    w_rw    = win_b ? b_rw      : a_rw;
    w_hold  = win_b ? b_hold    : a_hold;
    w_rel   = win_b ? b_release : a_release;
    w_addr  = win_b ? b_addr    : a_addr;
    w_wdata = win_b ? b_wdata   : a_wdata;
    w_self  = win_b ? OWN_B : OWN_A;
    w_other = win_b ? OWN_A : OWN_B;
    if ((w_hold && w_rel) || (PARTIAL && (int'(w_addr) >= NUM_REGS)))
      w_err = ERR_ILLEGAL;
    else if (owner[w_addr] == w_other)
      w_err = ERR_LOCKED;
    else if (w_rel && (owner[w_addr] != w_self))
      w_err = ERR_BADREL;
    else
      w_err = ERR_OK;
  end

  always_comb begin
    owns_a = 1'b0;
    owns_b = 1'b0;
    for (int i = 0; i < TBL; i++) begin
      if (owner[i] == OWN_A) owns_a = 1'b1;
      if (owner[i] == OWN_B) owns_b = 1'b1;
    end
  end

  assign grant_a_now = (state == S_GRANT) && !sel_b;
  assign grant_b_now = (state == S_GRANT) && sel_b;
  assign to_a = !a_req && owns_a && !grant_a_now && (cnt_a == CNT_W'(LOCK_TIMEOUT - 1));
  assign to_b = !b_req && owns_b && !grant_b_now && (cnt_b == CNT_W'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sel_b     <= 1'b0;
      favour_b  <= 1'b0;
      cur_rw    <= 1'b0;
      cur_hold  <= 1'b0;
      cur_rel   <= 1'b0;
      cur_addr  <= '0;
      cur_err   <= ERR_OK;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_ack     <= 1'b0;
      a_err     <= 2'b00;
      b_ack     <= 1'b0;
      b_err     <= 2'b00;
      rd_a      <= 1'b0;
      rd_b      <= 1'b0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      for (int i = 0; i < TBL; i++) owner[i] <= OWN_FREE;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_ack     <= 1'b0;
      a_err     <= 2'b00;
      b_ack     <= 1'b0;
      b_err     <= 2'b00;
      rd_a      <= 1'b0;
      rd_b      <= 1'b0;

      for (int i = 0; i < TBL; i++) begin
        if (to_a && owner[i] == OWN_A) owner[i] <= OWN_FREE;
        if (to_b && owner[i] == OWN_B) owner[i] <= OWN_FREE;
      end
      if (a_req || !owns_a || grant_a_now || to_a) cnt_a <= '0;
      else                                         cnt_a <= cnt_a + CNT_W'(1);
      if (b_req || !owns_b || grant_b_now || to_b) cnt_b <= '0;
      else                                         cnt_b <= cnt_b + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            state    <= S_GRANT;
            sel_b    <= win_b;
            cur_rw   <= w_rw;
            cur_hold <= w_hold;
            cur_rel  <= w_rel;
            cur_addr <= w_addr;
            cur_err  <= w_err;
            // The round-robin pointer only moves when a tie is actually arbitrated.
            if (a_req && b_req) favour_b <= !win_b;
            if (w_err == ERR_OK) begin
              mem_en    <= 1'b1;
              mem_we    <= w_rw;
              mem_addr  <= w_addr;
              mem_wdata <= w_rw ? w_wdata : '0;
            end
          end
        end
        S_GRANT: begin
          state <= S_RESP;
          if (sel_b) begin
            b_ack <= 1'b1;
            b_err <= cur_err;
            rd_b  <= (cur_err == ERR_OK) && !cur_rw;
          end else begin
            a_ack <= 1'b1;
            a_err <= cur_err;
            rd_a  <= (cur_err == ERR_OK) && !cur_rw;
          end
          if ((cur_err == ERR_OK) && cur_hold) owner[cur_addr] <= sel_b ? OWN_B : OWN_A;
        end
        S_RESP: begin
          state <= S_IDLE;
          if ((cur_err == ERR_OK) && cur_rel) owner[cur_addr] <= OWN_FREE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
